// File: rtl/integrate_cpu.sv
// rtl/integrate_cpu.sv - 8-bit accumulator CPU with built-in countdown program ROM
//
// Purpose: controller FSM plus datapath (A, PC, IR, Nout) running a fixed
// 16-word ROM program that reads N on enter, outputs N down to 0, then halts.
//
// Ports:
//   clock       in   rising-edge system clock
//   reset       in   asynchronous active-high reset, clears all state
//   enter       in   input-ready strobe for IN, level-sampled on clock edges
//   Nin         in   [DW-1:0] data loaded into A by IN
//   halt        out  high while the FSM is in HALT
//   Nout        out  [DW-1:0] output register, loaded from A by OUT
//   IR75out     out  [2:0] current opcode IR[7:5]
//   StateNoout  out  [3:0] current FSM state encoding

module integrate_cpu #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          enter,
  input  logic [DW-1:0] Nin,
  output logic          halt,
  output logic [DW-1:0] Nout,
  output logic [2:0]    IR75out,
  output logic [3:0]    StateNoout
);

  typedef enum logic [3:0] {
    S_START  = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_IN     = 4'd8,
    S_OUT    = 4'd9,
    S_DEC    = 4'd10,
    S_JNZ    = 4'd11,
    S_HALT   = 4'd12
  } state_t;

  state_t        state, state_next;
  logic [DW-1:0] a;
  logic [AW-1:0] pc;
  logic [DW-1:0] ir;
  logic [DW-1:0] rom_data;

  logic load_ir;
  logic load_a_in;
  logic dec_a;
  logic load_out;
  logic jump;

  // Program ROM: IN, OUT, DEC, JNZ 1, OUT, then HALT everywhere else.
  always_comb begin
    rom_data = 8'h80;
    case (pc)
      4'd0:    rom_data = 8'h00;
      4'd1:    rom_data = 8'h20;
      4'd2:    rom_data = 8'h40;
      4'd3:    rom_data = 8'h61;
      4'd4:    rom_data = 8'h20;
      default: rom_data = 8'h80;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_START;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = S_START;
    load_ir    = 1'b0;
    load_a_in  = 1'b0;
    dec_a      = 1'b0;
    load_out   = 1'b0;
    jump       = 1'b0;
    case (state)
      S_START:  state_next = S_FETCH;
      S_FETCH: begin
        load_ir    = 1'b1;
        state_next = S_DECODE;
      end
      S_DECODE: begin
        case (ir[7:5])
          3'b000:  state_next = S_IN;
          3'b001:  state_next = S_OUT;
          3'b010:  state_next = S_DEC;
          3'b011:  state_next = S_JNZ;
          3'b100:  state_next = S_HALT;
          default: state_next = S_FETCH;
        endcase
      end
      S_IN: begin
        if (enter) begin
          load_a_in  = 1'b1;
          state_next = S_FETCH;
        end else begin
          state_next = S_IN;
        end
      end
      S_OUT: begin
        load_out   = 1'b1;
        state_next = S_FETCH;
      end
      S_DEC: begin
        dec_a      = 1'b1;
        state_next = S_FETCH;
      end
      S_JNZ: begin
        jump       = (a != '0);
        state_next = S_FETCH;
      end
      S_HALT:   state_next = S_HALT;
      default:  state_next = S_START;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a    <= '0;
      pc   <= '0;
      ir   <= '0;
      Nout <= '0;
    end else begin
      if (load_ir) begin
        ir <= rom_data;
        pc <= pc + 1'b1;
      end else if (jump) begin
        pc <= ir[AW-1:0];
      end
      if (load_a_in) begin
        a <= Nin;
      end else if (dec_a) begin
        a <= a - 1'b1;
      end
      if (load_out) begin
        Nout <= a;
      end
    end
  end

  assign halt       = (state == S_HALT);
  assign IR75out    = ir[7:5];
  assign StateNoout = state;

endmodule

// File: tb/tb_integrate_cpu.sv
// tb/tb_integrate_cpu.sv - directed self-checking bench for integrate_cpu

module tb_integrate_cpu;

  logic       clock;
  logic       reset;
  logic       enter;
  logic [7:0] Nin;
  logic       halt;
  logic [7:0] Nout;
  logic [2:0] IR75out;
  logic [3:0] StateNoout;

  int vectors;
  int miscompares;
  int outs[$];
  int cycles_run;

  integrate_cpu #(.DW(8), .AW(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .enter      (enter),
    .Nin        (Nin),
    .halt       (halt),
    .Nout       (Nout),
    .IR75out    (IR75out),
    .StateNoout (StateNoout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Runs until halt (or the cycle bound), capturing Nout after every OUT state.
  task automatic collect_until_halt(input int max_cycles);
    bit was_out;
    outs.delete();
    cycles_run = 0;
    while (!halt && cycles_run < max_cycles) begin
      was_out = (StateNoout == 4'd9);
      @(negedge clock);
      cycles_run++;
      if (was_out) outs.push_back(int'(Nout));
    end
    vectors++;
    if (halt !== 1'b1) begin
      miscompares++;
      $display("FAIL halt_timeout: halt=%b after %0d cycles, required 1", halt, cycles_run);
    end
  endtask

  task automatic start_run(input logic [7:0] n, input logic en);
    reset = 1'b1;
    enter = en;
    Nin   = n;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic check_outs(input string name, input int exp[$]);
    vectors++;
    if (outs.size() != exp.size()) begin
      miscompares++;
      $display("FAIL %s_len: got %0d outputs, required %0d", name, outs.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < outs.size(); i++) begin
      vectors++;
      if (outs[i] != exp[i]) begin
        miscompares++;
        $display("FAIL %s[%0d]: Nout=%0d, required %0d", name, i, outs[i], exp[i]);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    enter = 1'b0;
    Nin   = 8'd0;
    #1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      vectors++;
      if ({StateNoout, Nout, halt, IR75out} !== {4'd0, 8'd0, 1'b0, 3'd0}) begin
        miscompares++;
        $display("FAIL reset_hold: state=%0d Nout=%0d halt=%b ir=%0d, required 0/0/0/0",
                 StateNoout, Nout, halt, IR75out);
      end
    end
  endtask

  task automatic test_startup_wait();
    logic [3:0] exp_states[8] = '{4'd0, 4'd1, 4'd2, 4'd8, 4'd8, 4'd8, 4'd8, 4'd8};
    start_run(8'd5, 1'b0);
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (StateNoout !== exp_states[i] || IR75out !== 3'd0) begin
        miscompares++;
        $display("FAIL startup_state[%0d]: state=%0d ir=%0d, required state=%0d ir=0",
                 i, StateNoout, IR75out, exp_states[i]);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_countdown9();
    start_run(8'd9, 1'b0);
    repeat (6) @(negedge clock);
    enter = 1'b1;
    @(negedge clock);
    enter = 1'b0;
    collect_until_halt(500);
    check_outs("count9", '{9, 8, 7, 6, 5, 4, 3, 2, 1, 0});
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if ({halt, StateNoout, IR75out, Nout} !== {1'b1, 4'd12, 3'd4, 8'd0}) begin
        miscompares++;
        $display("FAIL halt_stable[%0d]: halt=%b state=%0d ir=%0d Nout=%0d, required 1/12/4/0",
                 i, halt, StateNoout, IR75out, Nout);
      end
      repeat (3) @(negedge clock);
    end
  endtask

  task automatic test_enter_held();
    start_run(8'd1, 1'b1);
    collect_until_halt(60);
    vectors++;
    if (cycles_run != 18) begin
      miscompares++;
      $display("FAIL held_latency: halt after %0d cycles, required 18", cycles_run);
    end
    check_outs("held1", '{1, 0});
  endtask

  task automatic test_wrap();
    int exp[$];
    start_run(8'd0, 1'b1);
    collect_until_halt(4000);
    exp.push_back(0);
    for (int v = 255; v >= 1; v--) exp.push_back(v);
    exp.push_back(0);
    check_outs("wrap0", exp);
  endtask

  task automatic test_nin_change();
    start_run(8'd3, 1'b0);
    repeat (5) @(negedge clock);
    Nin = 8'd7;
    repeat (2) @(negedge clock);
    Nin   = 8'd2;
    enter = 1'b1;
    @(negedge clock);
    enter = 1'b0;
    Nin   = 8'd200;
    collect_until_halt(500);
    check_outs("ninchg", '{2, 1, 0});
  endtask

  task automatic test_reset_mid();
    int guard;
    start_run(8'd9, 1'b1);
    guard = 0;
    while (Nout !== 8'd5 && guard < 500) begin
      @(negedge clock);
      guard++;
    end
    vectors++;
    if (Nout !== 8'd5) begin
      miscompares++;
      $display("FAIL mid_reach5: Nout=%0d, required 5", Nout);
    end
    @(negedge clock);
    #3;
    reset = 1'b1;
    enter = 1'b0;
    #1;
    vectors++;
    if ({StateNoout, Nout, halt, IR75out} !== {4'd0, 8'd0, 1'b0, 3'd0}) begin
      miscompares++;
      $display("FAIL mid_async_reset: state=%0d Nout=%0d halt=%b ir=%0d, required 0/0/0/0",
               StateNoout, Nout, halt, IR75out);
    end
    @(negedge clock);
    reset = 1'b0;
    Nin   = 8'd2;
    repeat (4) @(negedge clock);
    vectors++;
    if (StateNoout !== 4'd8 || IR75out !== 3'd0 || Nout !== 8'd0) begin
      miscompares++;
      $display("FAIL mid_rerun_in: state=%0d ir=%0d Nout=%0d, required 8/0/0",
               StateNoout, IR75out, Nout);
    end
    enter = 1'b1;
    @(negedge clock);
    enter = 1'b0;
    collect_until_halt(500);
    check_outs("rerun", '{2, 1, 0});
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    enter       = 1'b0;
    Nin         = 8'd0;
    test_reset();
    test_startup_wait();
    test_countdown9();
    test_enter_held();
    test_wrap();
    test_nin_change();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/integrate_cpu.md
Name: integrate_cpu

Overview:
- Minimal 8-bit accumulator microprocessor: a controller FSM plus a datapath (A, PC, IR, output register) and a built-in 16x8 program ROM.
- The ROM holds a countdown program. It reads N from Nin when enter is asserted, outputs N, N-1, ... 1, then 0, and halts.
- Top-level integration block; IR opcode and FSM state number are exported for debug.

Parameters:
- DW, 8, data and instruction width.
- AW, 4, address width (ROM depth 2^AW = 16).

Ports:
- clock  input  1  system clock; all registers update on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- enter  input  1  input-ready strobe for the IN instruction; level-sampled on clock edges.
- Nin  input  8  input data loaded into A by IN.
- halt  output  1  high while the FSM is in HALT.
- Nout  output  8  output register, loaded from A by OUT.
- IR75out  output  3  IR[7:5], the current opcode.
- StateNoout  output  4  current FSM state encoding.

Behaviour:
- Reset (asynchronous, reset=1):
  - PC=0, A=0, IR=0, Nout=0, halt=0, state=START (0).
  - Outputs hold these values for as long as reset is high.
- Instruction format: IR[7:5] is the opcode, IR[4] is unused, IR[3:0] is the jump address.
- Opcodes:
  - 000 IN: wait for enter, then A<=Nin.
  - 001 OUT: Nout<=A.
  - 010 DEC: A<=A-1, modulo 256 (0 wraps to 255).
  - 011 JNZ: if A!=0 then PC<=IR[3:0].
  - 100 HALT.
  - 101/110/111: no-op.
- State encoding: START=0, FETCH=1, DECODE=2, IN=8, OUT=9, DEC=10, JNZ=11, HALT=12. All other codes are unused and recover to START.
- START: transitions to FETCH on the next edge.
- FETCH: IR<=ROM[PC], PC<=PC+1 (4-bit, wraps 15->0); transitions to DECODE.
- DECODE: branches on IR[7:5] to the execute state. No-op opcodes go straight to FETCH.
- IN: stays in IN while enter=0. On an edge with enter=1, A<=Nin and the FSM goes to FETCH.
- OUT, DEC, JNZ: perform the operation in one cycle, then go to FETCH.
- HALT: absorbing state, halt=1, left only by reset. A, PC and Nout are frozen.
- Instruction latency: 3 cycles per instruction (FETCH, DECODE, execute), plus wait cycles in IN.
- IR75out follows IR combinationally. StateNoout and halt are combinational from the state register.
- ROM contents (combinational read, constant), listed as address: data:
  - 0: 0x00 (IN)
  - 1: 0x20 (OUT)
  - 2: 0x40 (DEC)
  - 3: 0x61 (JNZ 1)
  - 4: 0x20 (OUT)
  - 5: 0x80 (HALT)
  - 6-15: 0x80 (HALT)
- Boundary conditions:
  - Nin=0: DEC wraps A to 255. JNZ loops until A returns to 0, so Nout outputs 0, 255, ..., 1, then 0, then halt.
  - enter held high continuously: IN completes on the first IN cycle.
  - Nin changing while waiting in IN: only the value sampled on the accepting edge is loaded.
  - Reset asserted mid-instruction: immediate return to the reset values; execution restarts at PC=0 after release.

Test Plan:
- Hold reset=1 -> StateNoout=0, Nout=0, halt=0, IR75out=0 throughout.
- Release reset with enter=0 -> states 0,1,2,8, then the FSM stays in 8 with IR75out=000.
- Nin=9, pulse enter -> Nout sequence 9,8,7,6,5,4,3,2,1,0; then halt=1, StateNoout=12, IR75out=100, Nout=0 stays stable.
- Nin=1 with enter held high -> Nout=1 then 0; halt asserts after exactly 18 cycles from release of reset:
  - START: 1 cycle
  - IN: 3 cycles
  - one OUT/DEC/JNZ loop: 9 cycles
  - OUT: 3 cycles
  - HALT FETCH/DECODE: 2 cycles
- Nin=0 -> DEC wrap: Nout shows 0 then 255, and the count continues down.
- Assert reset mid-countdown (Nout=5) -> all outputs return to reset values asynchronously; on release the program reruns from IN.
